// File: rtl/uc_cuenta_n.sv
`default_nettype none
// ============================================================================
// Module   : uc_cuenta_n
// Brief    : Control unit that sequences a shift-and-add ones counter over an
//            N-bit operand, with an optional early exit once Q is all zero.
// Revision : 1.0 - initial release
// ============================================================================
module uc_cuenta_n #(
  parameter int N          = 3,
  parameter bit EARLY_EXIT = 1'b0,
  parameter int CW         = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_zero,
  output logic carga_q,
  output logic desplaza_q,
  output logic reset_a,
  output logic carga_a,
  output logic busy,
  output logic fin
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_LAST_STEP = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carga_q    = 1'b0;
    desplaza_q = 1'b0;
    reset_a    = 1'b0;
    carga_a    = 1'b0;
    busy       = 1'b0;
    fin        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        carga_q = 1'b1;
        reset_a = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = S_STEP;
      end

      S_STEP: begin
        busy = 1'b1;
        // An all-zero Q cannot add any more ones, so stop without touching A or Q.
        if (EARLY_EXIT && q_zero) begin
          state_d = S_DONE;
        end else begin
          desplaza_q = 1'b1;
          carga_a    = q0;
          if (cnt_q == C_LAST_STEP) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        fin = 1'b1;
        // Leaving only on start=0 means a held start never re-arms a count.
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uc_cuenta_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_cuenta_n
// Brief    : Scoreboard bench for uc_cuenta_n with three instances
//            (N=3, N=3 early exit, N=8) driving small Q/A datapath models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uc_cuenta_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output vector: {carga_q, reset_a, desplaza_q, carga_a, busy, fin}
  logic [5:0] sbq[$];
  int         aq[$];

  // ---------------- instance 0: N=3, no early exit ----------------
  logic [2:0] valor3, q3;
  logic [7:0] a3;
  logic cq3, dq3, ra3, ca3, bz3, fn3;

  uc_cuenta_n #(.N(3), .EARLY_EXIT(1'b0)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .q0(q3[0]), .q_zero(q3 == 3'd0),
    .carga_q(cq3), .desplaza_q(dq3), .reset_a(ra3), .carga_a(ca3),
    .busy(bz3), .fin(fn3)
  );

  always @(posedge clk) begin
    if (cq3) q3 <= valor3; else if (dq3) q3 <= q3 >> 1;
    if (ra3) a3 <= 8'd0; else if (ca3) a3 <= a3 + 8'd1;
  end

  // ---------------- instance 1: N=3, early exit ----------------
  logic [2:0] valor3e, q3e;
  logic [7:0] a3e;
  logic cq3e, dq3e, ra3e, ca3e, bz3e, fn3e;

  uc_cuenta_n #(.N(3), .EARLY_EXIT(1'b1)) u_dut3e (
    .clk(clk), .reset(reset), .start(start), .q0(q3e[0]), .q_zero(q3e == 3'd0),
    .carga_q(cq3e), .desplaza_q(dq3e), .reset_a(ra3e), .carga_a(ca3e),
    .busy(bz3e), .fin(fn3e)
  );

  always @(posedge clk) begin
    if (cq3e) q3e <= valor3e; else if (dq3e) q3e <= q3e >> 1;
    if (ra3e) a3e <= 8'd0; else if (ca3e) a3e <= a3e + 8'd1;
  end

  // ---------------- instance 2: N=8, no early exit ----------------
  logic [7:0] valor8, q8;
  logic [7:0] a8;
  logic cq8, dq8, ra8, ca8, bz8, fn8;

  uc_cuenta_n #(.N(8), .EARLY_EXIT(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .q0(q8[0]), .q_zero(q8 == 8'd0),
    .carga_q(cq8), .desplaza_q(dq8), .reset_a(ra8), .carga_a(ca8),
    .busy(bz8), .fin(fn8)
  );

  always @(posedge clk) begin
    if (cq8) q8 <= valor8; else if (dq8) q8 <= q8 >> 1;
    if (ra8) a8 <= 8'd0; else if (ca8) a8 <= a8 + 8'd1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs(input int sel);
    case (sel)
      0:       return {cq3, ra3, dq3, ca3, bz3, fn3};
      1:       return {cq3e, ra3e, dq3e, ca3e, bz3e, fn3e};
      default: return {cq8, ra8, dq8, ca8, bz8, fn8};
    endcase
  endfunction

  function automatic logic [7:0] a_of(input int sel);
    case (sel)
      0:       return a3;
      1:       return a3e;
      default: return a8;
    endcase
  endfunction

  // Runs one count on instance sel. n_hold keeps start high for that many
  // extra DONE cycles; abort_step>0 asserts reset in that STEP cycle.
  task automatic run_count(input int sel, input logic [7:0] val,
                           input int n_hold, input int abort_step);
    int         n;
    bit         ee;
    int         ones;
    int         cyc;
    logic [7:0] q;
    logic [5:0] exp_v;
    logic [5:0] got_v;
    logic       prev_fin;

    n  = (sel == 2) ? 8 : 3;
    ee = (sel == 1);
    start = 1'b0;
    case (sel)
      0:       valor3  = val[2:0];
      1:       valor3e = val[2:0];
      default: valor8  = val;
    endcase
    repeat (12) @(posedge clk);
    #1;

    sbq.delete();
    aq.delete();
    sbq.push_back(6'b110010);
    q    = (sel == 2) ? val : {5'd0, val[2:0]};
    ones = 0;
    for (int i = 0; i < n; i++) begin
      if (abort_step > 0 && i == abort_step) break;
      if (ee && q == 8'd0) begin
        sbq.push_back(6'b000010);
        break;
      end
      sbq.push_back({2'b00, 1'b1, q[0], 2'b10});
      ones += int'(q[0]);
      q = q >> 1;
    end
    if (abort_step == 0) begin
      for (int i = 0; i <= n_hold; i++) sbq.push_back(6'b000001);
      aq.push_back(ones);
    end
    sbq.push_back(6'b000000);

    start    = 1'b1;
    prev_fin = 1'b0;
    cyc      = 1;
    while (sbq.size() > 0) begin
      @(posedge clk);
      #1;
      exp_v = sbq.pop_front();
      got_v = obs(sel);
      chk($sformatf("out s%0d v%0h c%0d", sel, val, cyc), {26'd0, got_v}, {26'd0, exp_v});
      if (got_v[0] && !prev_fin) begin
        if (aq.size() > 0) chk($sformatf("a_final s%0d v%0h", sel, val),
                               {24'd0, a_of(sel)}, aq.pop_front());
        else chk($sformatf("fin_unexpected s%0d", sel), 32'd1, 32'd0);
      end
      prev_fin = got_v[0];
      if (n_hold == 0 || sbq.size() <= 1) start = 1'b0;
      if (abort_step > 0 && sbq.size() == 1) reset = 1'b1;
      cyc++;
    end
    reset = 1'b0;
    chk($sformatf("a_pending s%0d v%0h", sel, val), aq.size(), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b1;
    valor3  = '0;
    valor3e = '0;
    valor8  = '0;

    // Reset dominates a held start.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++)
        chk($sformatf("reset_out s%0d c%0d", s, c), {26'd0, obs(s)}, 32'd0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++)
      chk($sformatf("post_reset s%0d", s), {26'd0, obs(s)}, 32'd0);

    run_count(0, 8'b101, 0, 0);
    run_count(0, 8'b111, 0, 0);
    run_count(0, 8'b000, 0, 0);
    run_count(0, 8'b101, 10, 0);
    run_count(0, 8'b011, 0, 0);

    run_count(1, 8'b001, 0, 0);
    run_count(1, 8'b000, 0, 0);
    run_count(1, 8'b110, 0, 0);
    run_count(1, 8'b111, 0, 0);

    run_count(2, 8'hFF, 0, 4);
    run_count(2, 8'hFF, 0, 0);
    run_count(2, 8'hA5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
